fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Instruction-fetch controller for the 16-bit core. Drives the 5-bit program-memory address, gathers one- or two-word instructions, and issues each one to the execute unit over a valid/ready handshake. It resolves jumps and conditional branches at issue time and halts on the erased-memory word.

## Interface
- `HALT_WORD`, 16'hFFFF: opcode-position word that stops fetching.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: in IDLE, begin fetching at address 0.
- `pc` out 5: program-memory address (registered).
- `instr_in` in 16: program-memory read data for `pc`, combinational, same cycle.
- `zero_flag` in 1: ALU zero flag, reflecting all previously accepted instructions.
- `issue_valid` out 1: an instruction is presented to execute.
- `issue_ready` in 1: execute accepts the presented instruction.
- `issue_instr` out 16: opcode word.
- `issue_imm` out 16: second word. Zero for single-word instructions.
- `issue_pc` out 5: address of the opcode word.
- `halted` out 1: sequencer stopped on `HALT_WORD`.

## Operation
- Opcode is `instr[15:12]`.
- Two-word opcodes: 0000 LOADI, 0100 XORI, 0110 ADDI, 0111 CMPI, 1001 SUBI. All other opcodes are single-word.
- Target field is `instr[11:7]`.
  - 0101 JMP: always taken.
  - 1000 BNZ: taken when `zero_flag`==0.
- States and transitions:
  - IDLE: `pc`=0. On `start`=1, go to FETCH.
  - FETCH:
    - If `instr_in`==`HALT_WORD`: go to HALT, `pc` unchanged.
    - Otherwise: latch `instr_in` into `issue_instr`, `issue_pc`<=`pc`, `pc`<=`pc`+1.
    - Two-word opcode: go to FETCH_IMM. Single-word: clear `issue_imm` and go to ISSUE.
  - FETCH_IMM: latch `instr_in` into `issue_imm` (any value, including `HALT_WORD`), `pc`<=`pc`+1, go to ISSUE.
  - ISSUE:
    - `issue_valid`=1. Stay in ISSUE until `issue_ready`=1.
    - On handshake: if JMP, or BNZ with `zero_flag`==0, `pc`<=target. Otherwise `pc` is kept. Go to FETCH.
  - HALT: `halted`=1, `issue_valid`=0. Leave only by reset.
- `start` is ignored outside IDLE.
- JMP and BNZ are still issued. Execute treats them as NOPs. The handshake serves as the flag barrier.
- `pc` arithmetic is modulo 32: 31+1 wraps to 0. A two-word opcode at 31 takes its immediate from address 0.

## Timing
- Reset (`rst_n`=0 at an edge, any state, including mid-handshake): state IDLE; `pc`, `issue_instr`, `issue_imm`, `issue_pc` = 0; `issue_valid`, `halted` = 0. Effective from that edge.
- `issue_valid` and `issue_*` are registered. While `issue_valid`=1 and `issue_ready`=0, they are held stable and `pc` is frozen.
- `issue_valid` falls on the edge that completes the handshake. There is no back-to-back issue.
- Throughput with `issue_ready` tied high:
  - single-word instruction: 2 cycles (FETCH, ISSUE);
  - two-word instruction: 3 cycles.
- `start` to first `issue_valid`: 2 cycles for a single-word instruction at address 0, 3 cycles for a two-word one.
- `zero_flag` is sampled only on the BNZ handshake edge.
- `halted` rises the cycle after FETCH sees `HALT_WORD`.

## Structure
- Package `fetch_pkg` holds:
  - the opcode constants;
  - the `HALT_WORD` default;
  - the state enum (IDLE, FETCH, FETCH_IMM, ISSUE, HALT);
  - a function `has_imm(opcode)` returning the two-word class.
- One natural sub-module: `instr_class_decode`. Combinational; takes the opcode and returns `two_word`, `is_jmp`, `is_bnz`. Shared with the execute-side decoder.
- `fetch_sequencer` contains the FSM, `pc` register and issue registers only.

## Test plan
- Startup: pulse `start` with words 0x0000/0x0006 at 0–1, `issue_ready`=1.
  - `pc` steps 0→1→2.
  - `issue_valid` rises 3 cycles after `start`, with `issue_instr`=0x0000, `issue_imm`=0x0006, `issue_pc`=0.
- Backpressure: 0xA002 at address 2, `issue_ready` held low 4 cycles.
  - `issue_valid`=1 and `issue_instr`=0xA002 stay stable.
  - `pc` stays 3 throughout.
  - Fetch of address 3 starts the cycle after the handshake.
- Branch: 0x8A00 at address 23.
  - `zero_flag`=0 at handshake: next FETCH `pc`=20.
  - `zero_flag`=1 at handshake: next FETCH `pc`=24.
- Jump and wrap:
  - 0x5000 at 28: next `pc`=0.
  - Separately, 0x0000 at 31 with 0x1234 at address 0: `issue_imm`=0x1234, then `pc`=1.
- Halt: immediate 0xFFFF at address 25 under XORI 0x4200 is issued normally. 0xFFFF in opcode position at address 29 gives `halted`=1 next cycle, `issue_valid` never asserts, and `start` has no effect.
- Reset mid-operation: drive `rst_n`=0 while in ISSUE with `issue_valid`=1 and `issue_ready`=1.
  - Next edge: all outputs are at their reset values, the state is IDLE, and `pc` is not redirected.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-side definitions: opcodes, halt word, sequencer states and
// the two-word instruction classification.
package fetch_pkg;

  localparam logic [15:0] HALT_WORD_DFLT = 16'hFFFF;

  localparam logic [3:0] OP_LOADI = 4'b0000;
  localparam logic [3:0] OP_XORI  = 4'b0100;
  localparam logic [3:0] OP_JMP   = 4'b0101;
  localparam logic [3:0] OP_ADDI  = 4'b0110;
  localparam logic [3:0] OP_CMPI  = 4'b0111;
  localparam logic [3:0] OP_BNZ   = 4'b1000;
  localparam logic [3:0] OP_SUBI  = 4'b1001;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_FETCH_IMM = 3'd2,
    ST_ISSUE     = 3'd3,
    ST_HALT      = 3'd4
  } state_e;

  function automatic logic has_imm(input logic [3:0] opcode);
    logic res;
    case (opcode)
      OP_LOADI, OP_XORI, OP_ADDI, OP_CMPI, OP_SUBI: res = 1'b1;
      default:                                      res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/instr_class_decode.sv
// Opcode classifier shared by fetch and execute: instruction length and
// control-flow kind.
module instr_class_decode
  import fetch_pkg::*;
(
  input  logic [3:0] opcode_i,
  output logic       two_word_o,
  output logic       is_jmp_o,
  output logic       is_bnz_o
);

  // Pure opcode decode
  always_comb begin
    two_word_o = has_imm(opcode_i);
    is_jmp_o   = (opcode_i == OP_JMP);
    is_bnz_o   = (opcode_i == OP_BNZ);
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: walks program memory, gathers one- or
// two-word instructions and issues them over a valid/ready handshake.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [15:0] HALT_WORD = HALT_WORD_DFLT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [4:0]  pc,
  input  logic [15:0] instr_in,
  input  logic        zero_flag,
  output logic        issue_valid,
  input  logic        issue_ready,
  output logic [15:0] issue_instr,
  output logic [15:0] issue_imm,
  output logic [4:0]  issue_pc,
  output logic        halted
);

  state_e      state_q;
  logic [4:0]  pc_q;
  logic [4:0]  pc_d;
  logic [15:0] issue_instr_q;
  logic [15:0] issue_imm_q;
  logic [4:0]  issue_pc_q;
  logic        issue_valid_q;
  logic        halted_q;

  logic [3:0]  dec_opcode_s;
  logic        two_word_s;
  logic        is_jmp_s;
  logic        is_bnz_s;
  logic        take_s;
  logic        is_halt_s;

  // In ISSUE the held opcode decides the redirect; elsewhere the fetched word.
  assign dec_opcode_s = (state_q == ST_ISSUE) ? issue_instr_q[15:12] : instr_in[15:12];

  instr_class_decode u_decode (
    .opcode_i   (dec_opcode_s),
    .two_word_o (two_word_s),
    .is_jmp_o   (is_jmp_s),
    .is_bnz_o   (is_bnz_s)
  );

  assign take_s    = is_jmp_s | (is_bnz_s & ~zero_flag);
  assign is_halt_s = (instr_in == HALT_WORD);

  // Next program-memory address
  always_comb begin
    pc_d = pc_q;
    case (state_q)
      ST_IDLE: pc_d = 5'd0;
      ST_FETCH: begin
        if (is_halt_s) pc_d = pc_q;
        else           pc_d = pc_q + 5'd1;
      end
      ST_FETCH_IMM: pc_d = pc_q + 5'd1;
      ST_ISSUE: begin
        if (issue_ready && take_s) pc_d = issue_instr_q[11:7];
        else                       pc_d = pc_q;
      end
      ST_HALT: pc_d = pc_q;
      default: pc_d = 5'd0;
    endcase
  end

  // Sequencer FSM with registered issue outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pc_q          <= 5'd0;
      issue_instr_q <= 16'd0;
      issue_imm_q   <= 16'd0;
      issue_pc_q    <= 5'd0;
      issue_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      pc_q <= pc_d;
      case (state_q)
        ST_IDLE: begin
          if (start) state_q <= ST_FETCH;
          else       state_q <= ST_IDLE;
        end
        ST_FETCH: begin
          if (is_halt_s) begin
            state_q  <= ST_HALT;
            halted_q <= 1'b1;
          end else begin
            issue_instr_q <= instr_in;
            issue_pc_q    <= pc_q;
            if (two_word_s) begin
              state_q <= ST_FETCH_IMM;
            end else begin
              issue_imm_q   <= 16'd0;
              issue_valid_q <= 1'b1;
              state_q       <= ST_ISSUE;
            end
          end
        end
        ST_FETCH_IMM: begin
          issue_imm_q   <= instr_in;
          issue_valid_q <= 1'b1;
          state_q       <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (issue_ready) begin
            issue_valid_q <= 1'b0;
            state_q       <= ST_FETCH;
          end else begin
            state_q <= ST_ISSUE;
          end
        end
        ST_HALT: begin
          halted_q <= 1'b1;
          state_q  <= ST_HALT;
        end
        default: begin
          issue_valid_q <= 1'b0;
          state_q       <= ST_IDLE;
        end
      endcase
    end
  end

  assign pc          = pc_q;
  assign issue_valid = issue_valid_q;
  assign issue_instr = issue_instr_q;
  assign issue_imm   = issue_imm_q;
  assign issue_pc    = issue_pc_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: expected issues are queued per
// program and compared as the sequencer presents them.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  pc;
  logic [15:0] instr_in;
  logic        zero_flag = 1'b0;
  logic        issue_valid;
  logic        issue_ready = 1'b0;
  logic [15:0] issue_instr;
  logic [15:0] issue_imm;
  logic [4:0]  issue_pc;
  logic        halted;

  logic [15:0] mem [32];

  typedef struct {
    logic [15:0] instr;
    logic [15:0] imm;
    logic [4:0]  pc;
    int          len;
    int          delay;
    logic        zf;
    logic [4:0]  next_pc;
    int          gap;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_pass   = 0;

  fetch_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .pc          (pc),
    .instr_in    (instr_in),
    .zero_flag   (zero_flag),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .issue_instr (issue_instr),
    .issue_imm   (issue_imm),
    .issue_pc    (issue_pc),
    .halted      (halted)
  );

  assign instr_in = mem[pc];

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic push(input logic [15:0] instr, input logic [15:0] imm, input logic [4:0] p,
                      input int len, input int delay, input logic zf,
                      input logic [4:0] next_pc, input int gap);
    exp_t e;
    e.instr = instr; e.imm = imm; e.pc = p; e.len = len; e.delay = delay;
    e.zf = zf; e.next_pc = next_pc; e.gap = gap;
    sb.push_back(e);
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 32; i++) mem[i] = 16'h3000;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; issue_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_val("rst_pc", pc, 5'd0);
    check_val("rst_valid", issue_valid, 1'b0);
    check_val("rst_instr", issue_instr, 16'd0);
    check_val("rst_imm", issue_imm, 16'd0);
    check_val("rst_ipc", issue_pc, 5'd0);
    check_val("rst_halted", halted, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic service_one();
    exp_t e;
    int waits;
    logic [4:0] frozen;
    e = sb.pop_front();
    waits = 0;
    while (!issue_valid && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    if (!issue_valid) begin
      check_val("issue_timeout", issue_valid, 1'b1);
      return;
    end
    if (e.gap >= 0) check_val("gap", waits, e.gap);
    check_val("instr", issue_instr, e.instr);
    check_val("imm", issue_imm, e.imm);
    check_val("ipc", issue_pc, e.pc);
    frozen = e.pc + 5'(e.len);
    for (int i = 0; i < e.delay; i++) begin
      @(negedge clk);
      check_val("bp_valid", issue_valid, 1'b1);
      check_val("bp_instr", issue_instr, e.instr);
      check_val("bp_pc", pc, frozen);
    end
    issue_ready = 1'b1;
    zero_flag = e.zf;
    @(negedge clk);
    issue_ready = 1'b0;
    check_val("post_valid", issue_valid, 1'b0);
    check_val("next_pc", pc, e.next_pc);
  endtask

  task automatic drain();
    while (sb.size() > 0) service_one();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Startup, backpressure, branches, jump to 0
    fill_mem();
    mem[0] = 16'h0000; mem[1] = 16'h0006; mem[2] = 16'hA002; mem[3] = 16'h5B80;
    mem[23] = 16'h8A00; mem[20] = 16'h5B80;
    mem[24] = 16'h4200; mem[25] = 16'hFFFF; mem[26] = 16'h3000; mem[27] = 16'h1111;
    mem[28] = 16'h5000;
    do_reset();
    pulse_start();
    check_val("st_pc0", pc, 5'd0);
    check_val("st_valid0", issue_valid, 1'b0);
    @(negedge clk);
    check_val("st_pc1", pc, 5'd1);
    check_val("st_valid1", issue_valid, 1'b0);
    @(negedge clk);
    check_val("st_pc2", pc, 5'd2);
    check_val("st_valid2", issue_valid, 1'b1);
    push(16'h0000, 16'h0006, 5'd0,  2, 0, 1'b0, 5'd2,  0);
    push(16'hA002, 16'h0000, 5'd2,  1, 4, 1'b0, 5'd3,  1);
    push(16'h5B80, 16'h0000, 5'd3,  1, 0, 1'b1, 5'd23, 1);
    push(16'h8A00, 16'h0000, 5'd23, 1, 0, 1'b0, 5'd20, 1);
    push(16'h5B80, 16'h0000, 5'd20, 1, 0, 1'b0, 5'd23, 1);
    push(16'h8A00, 16'h0000, 5'd23, 1, 1, 1'b1, 5'd24, 1);
    push(16'h4200, 16'hFFFF, 5'd24, 2, 0, 1'b0, 5'd26, 2);
    push(16'h3000, 16'h0000, 5'd26, 1, 0, 1'b0, 5'd27, 1);
    push(16'h1111, 16'h0000, 5'd27, 1, 0, 1'b0, 5'd28, 1);
    push(16'h5000, 16'h0000, 5'd28, 1, 0, 1'b1, 5'd0,  1);
    drain();

    // Wrap: two-word opcode at 31 takes its immediate from address 0
    fill_mem();
    mem[0] = 16'h1234; mem[1] = 16'h5F80; mem[31] = 16'h0000;
    do_reset();
    pulse_start();
    push(16'h1234, 16'h0000, 5'd0,  1, 0, 1'b0, 5'd1,  -1);
    push(16'h5F80, 16'h0000, 5'd1,  1, 0, 1'b0, 5'd31, 1);
    push(16'h0000, 16'h1234, 5'd31, 2, 2, 1'b0, 5'd1,  2);
    drain();

    // Halt word as immediate is data; as opcode it stops the sequencer
    fill_mem();
    mem[0] = 16'h4200; mem[1] = 16'hFFFF; mem[2] = 16'h5C00;
    mem[24] = 16'h4200; mem[25] = 16'hFFFF; mem[26] = 16'h5E80; mem[29] = 16'hFFFF;
    do_reset();
    pulse_start();
    push(16'h4200, 16'hFFFF, 5'd0,  2, 0, 1'b0, 5'd2,  -1);
    push(16'h5C00, 16'h0000, 5'd2,  1, 0, 1'b0, 5'd24, 1);
    push(16'h4200, 16'hFFFF, 5'd24, 2, 0, 1'b0, 5'd26, 2);
    push(16'h5E80, 16'h0000, 5'd26, 1, 0, 1'b0, 5'd29, 1);
    drain();
    check_val("pre_halt", halted, 1'b0);
    @(negedge clk);
    check_val("halted", halted, 1'b1);
    check_val("halt_pc", pc, 5'd29);
    issue_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start = 1'b1;
      @(negedge clk);
      check_val("halt_stay", halted, 1'b1);
      check_val("halt_novalid", issue_valid, 1'b0);
      check_val("halt_pcfix", pc, 5'd29);
    end
    start = 1'b0;
    issue_ready = 1'b0;

    // Reset during a ready jump handshake must not redirect pc
    fill_mem();
    mem[0] = 16'h5B80;
    do_reset();
    pulse_start();
    @(negedge clk);
    check_val("rm_valid", issue_valid, 1'b1);
    check_val("rm_instr", issue_instr, 16'h5B80);
    issue_ready = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    check_val("rm_pc", pc, 5'd0);
    check_val("rm_vld", issue_valid, 1'b0);
    check_val("rm_ins", issue_instr, 16'd0);
    check_val("rm_imm", issue_imm, 16'd0);
    check_val("rm_ipc", issue_pc, 5'd0);
    check_val("rm_hlt", halted, 1'b0);
    issue_ready = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("idle_pc", pc, 5'd0);
      check_val("idle_valid", issue_valid, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
